// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: runs a req/ack fetch for the current PC and loads the
// {pc, inst} pair into the IF/ID register, honouring pipeline stall and flush.
module if_fetch_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic [5:0]        stall,
  input  logic              flush,
  output logic              ibus_req_o,
  output logic [ADDR_W-1:0] ibus_addr_o,
  input  logic [DATA_W-1:0] ibus_rdata_i,
  input  logic              ibus_ack_i,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o
);

  typedef enum logic [1:0] {StIdle, StWait, StHold, StFlushWait} state_e;

  state_e state_q, state_d;

  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [DATA_W-1:0] id_inst_q, id_inst_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
  logic [DATA_W-1:0] hold_inst_q, hold_inst_d;

  // Only the IF/ID and ID stall bits matter to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:3], stall[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ce_i && !flush) state_d = StWait;
      end
      StWait: begin
        if (ibus_ack_i) begin
          state_d = (flush || !stall[1]) ? StIdle : StHold;
        end else if (flush) begin
          // The bus cannot abort, so the flushed transaction must still drain.
          state_d = StFlushWait;
        end
      end
      StHold: begin
        if (flush || !stall[1]) state_d = StIdle;
      end
      StFlushWait: begin
        if (ibus_ack_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    logic capture_wait;
    logic capture_hold;
    logic buffer_wait;

    capture_wait = (state_q == StWait) && ibus_ack_i && !flush && !stall[1];
    capture_hold = (state_q == StHold) && !flush && !stall[1];
    buffer_wait  = (state_q == StWait) && ibus_ack_i && !flush && stall[1];

    stallreq_o = ((state_q == StIdle) && ce_i && !flush) ||
                 ((state_q == StWait) && !ibus_ack_i) ||
                 (state_q == StFlushWait);

    req_d  = req_q;
    addr_d = addr_q;
    if ((state_q == StIdle) && ce_i && !flush) begin
      req_d  = 1'b1;
      addr_d = pc_i;
    end else if (((state_q == StWait) || (state_q == StFlushWait)) && ibus_ack_i) begin
      req_d = 1'b0;
    end

    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    if (buffer_wait) begin
      hold_pc_d   = addr_q;
      hold_inst_d = ibus_rdata_i;
    end

    if (capture_wait) begin
      id_pc_d   = addr_q;
      id_inst_d = ibus_rdata_i;
    end else if (capture_hold) begin
      id_pc_d   = hold_pc_q;
      id_inst_d = hold_inst_q;
    end else if (!flush && stall[1] && stall[2]) begin
      id_pc_d   = id_pc_q;
      id_inst_d = id_inst_q;
    end else begin
      id_pc_d   = '0;
      id_inst_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= 1'b0;
      addr_q      <= '0;
      id_pc_q     <= '0;
      id_inst_q   <= '0;
      hold_pc_q   <= '0;
      hold_inst_q <= '0;
    end else begin
      req_q       <= req_d;
      addr_q      <= addr_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  assign ibus_req_o  = req_q;
  assign ibus_addr_o = addr_q;
  assign id_pc_o     = id_pc_q;
  assign id_inst_o   = id_inst_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a table of per-cycle vectors with hand-computed
// expectations, plus a hand-written asynchronous-reset sequence.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic [5:0]  stall;
  logic        flush;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic [31:0] ibus_rdata_i;
  logic        ibus_ack_i;
  logic        stallreq_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  int checks;
  int errors;

  if_fetch_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .ce_i         (ce_i),
    .stall        (stall),
    .flush        (flush),
    .ibus_req_o   (ibus_req_o),
    .ibus_addr_o  (ibus_addr_o),
    .ibus_rdata_i (ibus_rdata_i),
    .ibus_ack_i   (ibus_ack_i),
    .stallreq_o   (stallreq_o),
    .id_pc_o      (id_pc_o),
    .id_inst_o    (id_inst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    logic [5:0]  stall;
    logic        flush;
    logic        ack;
    logic [31:0] rdata;
    logic        e_sreq;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  function automatic vec_t mk(logic ce, logic [31:0] pc, logic [5:0] st, logic fl, logic ack,
                              logic [31:0] rdata, logic e_sreq, logic e_req,
                              logic [31:0] e_addr, logic [31:0] e_pc, logic [31:0] e_inst);
    vec_t v;
    v.ce = ce; v.pc = pc; v.stall = st; v.flush = fl; v.ack = ack; v.rdata = rdata;
    v.e_sreq = e_sreq; v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_inst = e_inst;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Inputs are driven just after a rising edge; stallreq is checked before the next
  // edge, registered outputs just after it.
  task automatic apply(input vec_t v, input int idx);
    ce_i = v.ce; pc_i = v.pc; stall = v.stall; flush = v.flush;
    ibus_ack_i = v.ack; ibus_rdata_i = v.rdata;
    @(negedge clk);
    check("stallreq", idx, {31'b0, stallreq_o}, {31'b0, v.e_sreq});
    @(posedge clk);
    #1;
    check("req", idx, {31'b0, ibus_req_o}, {31'b0, v.e_req});
    check("addr", idx, ibus_addr_o, v.e_addr);
    check("id_pc", idx, id_pc_o, v.e_pc);
    check("id_inst", idx, id_inst_o, v.e_inst);
  endtask

  localparam logic [5:0] S0  = 6'b000000;
  localparam logic [5:0] S12 = 6'b000110;
  localparam logic [5:0] S1  = 6'b000010;

  vec_t tbl[38];

  initial begin
    checks = 0;
    errors = 0;

    //          ce  pc            stall fl ack rdata          sreq req addr          id_pc         id_inst
    tbl[0]  = mk(1, 32'h80000000, S0,  0, 0, 32'h0,        1, 1, 32'h80000000, 32'h0,        32'h0);
    tbl[1]  = mk(1, 32'h80000000, S0,  0, 1, 32'h3C011234, 0, 0, 32'h80000000, 32'h80000000, 32'h3C011234);
    tbl[2]  = mk(1, 32'h80000004, S0,  0, 0, 32'h0,        1, 1, 32'h80000004, 32'h0,        32'h0);
    for (int i = 3; i <= 7; i++)
      tbl[i] = mk(1, 32'h80000008, S0, 0, 0, 32'h0,        1, 1, 32'h80000004, 32'h0,        32'h0);
    tbl[8]  = mk(1, 32'h80000008, S0,  0, 1, 32'h8C220000, 0, 0, 32'h80000004, 32'h80000004, 32'h8C220000);
    tbl[9]  = mk(1, 32'h80000008, S0,  0, 0, 32'h0,        1, 1, 32'h80000008, 32'h0,        32'h0);
    tbl[10] = mk(1, 32'h80000008, S0,  0, 0, 32'h0,        1, 1, 32'h80000008, 32'h0,        32'h0);
    tbl[11] = mk(1, 32'h80000180, S0,  1, 0, 32'h0,        1, 1, 32'h80000008, 32'h0,        32'h0);
    tbl[12] = mk(1, 32'h80000180, S0,  1, 0, 32'h0,        1, 1, 32'h80000008, 32'h0,        32'h0);
    tbl[13] = mk(1, 32'h80000180, S0,  0, 0, 32'h0,        1, 1, 32'h80000008, 32'h0,        32'h0);
    tbl[14] = mk(1, 32'h80000180, S0,  0, 1, 32'hDEADBEEF, 1, 0, 32'h80000008, 32'h0,        32'h0);
    tbl[15] = mk(1, 32'h80000180, S0,  0, 0, 32'h0,        1, 1, 32'h80000180, 32'h0,        32'h0);
    tbl[16] = mk(1, 32'h80000180, S0,  0, 1, 32'h11110000, 0, 0, 32'h80000180, 32'h80000180, 32'h11110000);
    tbl[17] = mk(1, 32'h80000184, S12, 0, 0, 32'h0,        1, 1, 32'h80000184, 32'h80000180, 32'h11110000);
    tbl[18] = mk(1, 32'h80000184, S12, 0, 1, 32'h24020005, 0, 0, 32'h80000184, 32'h80000180, 32'h11110000);
    tbl[19] = mk(1, 32'h80000188, S12, 0, 0, 32'h0,        0, 0, 32'h80000184, 32'h80000180, 32'h11110000);
    tbl[20] = mk(1, 32'h80000188, S12, 0, 0, 32'h0,        0, 0, 32'h80000184, 32'h80000180, 32'h11110000);
    tbl[21] = mk(1, 32'h80000188, S0,  0, 0, 32'h0,        0, 0, 32'h80000184, 32'h80000184, 32'h24020005);
    tbl[22] = mk(1, 32'h80000188, S0,  0, 0, 32'h0,        1, 1, 32'h80000188, 32'h0,        32'h0);
    tbl[23] = mk(1, 32'h80000188, S12, 0, 1, 32'h55AA55AA, 0, 0, 32'h80000188, 32'h0,        32'h0);
    tbl[24] = mk(1, 32'h8000018C, S12, 1, 0, 32'h0,        0, 0, 32'h80000188, 32'h0,        32'h0);
    tbl[25] = mk(1, 32'h8000018C, S0,  0, 0, 32'h0,        1, 1, 32'h8000018C, 32'h0,        32'h0);
    tbl[26] = mk(1, 32'h8000018C, S0,  0, 1, 32'h0000ABCD, 0, 0, 32'h8000018C, 32'h8000018C, 32'h0000ABCD);
    tbl[27] = mk(0, 32'h80000190, S0,  0, 0, 32'h0,        0, 0, 32'h8000018C, 32'h0,        32'h0);
    tbl[28] = mk(0, 32'h80000190, S0,  0, 1, 32'hFFFFFFFF, 0, 0, 32'h8000018C, 32'h0,        32'h0);
    tbl[29] = mk(0, 32'h80000190, S0,  0, 0, 32'h0,        0, 0, 32'h8000018C, 32'h0,        32'h0);
    tbl[30] = mk(0, 32'h80000190, S0,  0, 0, 32'h0,        0, 0, 32'h8000018C, 32'h0,        32'h0);
    tbl[31] = mk(1, 32'h80000200, S0,  0, 0, 32'h0,        1, 1, 32'h80000200, 32'h0,        32'h0);
    tbl[32] = mk(1, 32'h80000200, S0,  1, 1, 32'h12345678, 0, 0, 32'h80000200, 32'h0,        32'h0);
    tbl[33] = mk(0, 32'h80000200, S0,  0, 0, 32'h0,        0, 0, 32'h80000200, 32'h0,        32'h0);
    tbl[34] = mk(1, 32'h80000204, S0,  1, 0, 32'h0,        0, 0, 32'h80000200, 32'h0,        32'h0);
    tbl[35] = mk(1, 32'h80000204, S0,  0, 0, 32'h0,        1, 1, 32'h80000204, 32'h0,        32'h0);
    tbl[36] = mk(1, 32'h80000204, S0,  0, 1, 32'hA5A5A5A5, 0, 0, 32'h80000204, 32'h80000204, 32'hA5A5A5A5);
    tbl[37] = mk(0, 32'h80000208, S1,  0, 0, 32'h0,        0, 0, 32'h80000204, 32'h0,        32'h0);

    rst = 1'b1; ce_i = 1'b0; pc_i = '0; stall = '0; flush = 1'b0;
    ibus_ack_i = 1'b0; ibus_rdata_i = '0;
    #12;
    check("rst_req", -1, {31'b0, ibus_req_o}, 32'h0);
    check("rst_addr", -1, ibus_addr_o, 32'h0);
    check("rst_id_pc", -1, id_pc_o, 32'h0);
    check("rst_id_inst", -1, id_inst_o, 32'h0);
    check("rst_stallreq", -1, {31'b0, stallreq_o}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 38; i++) apply(tbl[i], i);

    // Capture a word, start another fetch with ID stalled, then reset mid-WAIT.
    apply(mk(1, 32'h80000300, S0,  0, 0, 32'h0,        1, 1, 32'h80000300, 32'h0,        32'h0), 100);
    apply(mk(1, 32'h80000300, S0,  0, 1, 32'h0F0F0F0F, 0, 0, 32'h80000300, 32'h80000300, 32'h0F0F0F0F), 101);
    apply(mk(1, 32'h80000304, S12, 0, 0, 32'h0,        1, 1, 32'h80000304, 32'h80000300, 32'h0F0F0F0F), 102);
    ibus_ack_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_req", 103, {31'b0, ibus_req_o}, 32'h0);
    check("async_addr", 103, ibus_addr_o, 32'h0);
    check("async_id_pc", 103, id_pc_o, 32'h0);
    check("async_id_inst", 103, id_inst_o, 32'h0);
    #2;
    rst = 1'b0;
    ce_i = 1'b0;
    stall = S0;
    #1;
    check("post_rst_stallreq", 104, {31'b0, stallreq_o}, 32'h0);
    @(posedge clk);
    #1;
    apply(mk(1, 32'h80000308, S0,  0, 0, 32'h0,        1, 1, 32'h80000308, 32'h0,        32'h0), 105);
    apply(mk(1, 32'h80000308, S0,  0, 1, 32'h01234567, 0, 0, 32'h80000308, 32'h80000308, 32'h01234567), 106);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
